// File: rtl/sobel_stream_ctrl_if.sv
// Pixel-stream handshake and window-status bundle for the Sobel sequencer.
// The master side drives pixel qualifiers. The slave side (the controller) reports
// line-buffer shifting, window validity and frame status.
interface sobel_stream_ctrl_if #(
    parameter int COORD_W = 11
);
    logic               en;
    logic               hsync;
    logic               vsync;
    logic               shift_en;
    logic               win_valid;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;
    logic               frame_done;
    logic               line_err;

    modport master (
        output en, hsync, vsync,
        input  shift_en, win_valid, win_x, win_y, frame_done, line_err
    );

    modport slave (
        input  en, hsync, vsync,
        output shift_en, win_valid, win_x, win_y, frame_done, line_err
    );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// Sobel line-buffer / window sequencer.
// Tracks the row/column of every accepted pixel and gates line-buffer shifting.
// Launches a window token for each pixel that completes a 3x3 neighbourhood.
// Delays the token to match datapath latency, and reports end-of-frame and
// line-length errors.
module sobel_stream_ctrl #(
    parameter int FRAME_WIDTH  = 297,
    parameter int FRAME_HEIGHT = 240,
    parameter int COORD_W      = 11,
    parameter int LATENCY      = 1
) (
    input  logic               clk,
    input  logic               reset,
    sobel_stream_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(FRAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(FRAME_HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col_next;
    logic [COORD_W-1:0] row_next;
    logic [COORD_W-1:0] pix_col;
    logic [COORD_W-1:0] pix_row;
    logic               accept;
    logic               line_break;
    logic               pix_last;
    logic               launch;
    logic               line_err_q;

    logic [LATENCY-1:0] pipe_valid;
    logic [LATENCY-1:0] pipe_last;
    logic [COORD_W-1:0] pipe_x [LATENCY];
    logic [COORD_W-1:0] pipe_y [LATENCY];

    // Decide whether this cycle's pixel is taken and which coordinates it really has
    always_comb begin
        accept     = 1'b0;
        line_break = 1'b0;
        pix_col    = col;
        pix_row    = row;
        if (bus.vsync) begin
            accept  = bus.en;
            pix_col = '0;
            pix_row = '0;
        end else begin
            accept = bus.en && (state == FILL || state == RUN);
            if (bus.hsync && col != '0) begin
                line_break = accept;
                pix_col    = '0;
                pix_row    = row + ONE;
            end
        end
        pix_last = accept && (pix_row == ROW_LAST) && (pix_col == COL_LAST);
        launch   = accept && (pix_row >= TWO) && (pix_col >= TWO);
    end

    // Advance the coordinate counters and choose the next sequencing state
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        if (accept) begin
            if (pix_col == COL_LAST) begin
                col_next = '0;
                row_next = pix_row + ONE;
            end else begin
                col_next = pix_col + ONE;
                row_next = pix_row;
            end
        end else if (bus.vsync) begin
            col_next = '0;
            row_next = '0;
        end

        case (state)
            IDLE:    state_next = IDLE;
            FILL:    if (row_next >= TWO) state_next = RUN;
            RUN:     state_next = RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (bus.vsync) begin
            state_next = FILL;
        end
        if (pix_last) begin
            state_next = DONE;
        end
    end

    // Sequencing state, counters and the per-frame sticky line error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            line_err_q <= 1'b0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
            if (bus.vsync) begin
                line_err_q <= 1'b0;
            end else if (line_break) begin
                line_err_q <= 1'b1;
            end
        end
    end

    // Window token delay line; vsync drops tokens in flight, coordinates hold between tokens
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_x[k] <= '0;
                pipe_y[k] <= '0;
            end
        end else begin
            if (bus.vsync) begin
                pipe_valid <= '0;
                pipe_last  <= '0;
            end else begin
                pipe_valid[0] <= launch;
                pipe_last[0]  <= launch && pix_last;
                for (int k = 1; k < LATENCY; k++) begin
                    pipe_valid[k] <= pipe_valid[k-1];
                    pipe_last[k]  <= pipe_last[k-1];
                end
            end
            if (launch && !bus.vsync) begin
                pipe_x[0] <= pix_col - ONE;
                pipe_y[0] <= pix_row - ONE;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (pipe_valid[k-1] && !bus.vsync) begin
                    pipe_x[k] <= pipe_x[k-1];
                    pipe_y[k] <= pipe_y[k-1];
                end
            end
        end
    end

    assign bus.shift_en   = accept;
    assign bus.win_valid  = pipe_valid[LATENCY-1];
    assign bus.frame_done = pipe_last[LATENCY-1];
    assign bus.win_x      = pipe_x[LATENCY-1];
    assign bus.win_y      = pipe_y[LATENCY-1];
    assign bus.line_err   = line_err_q;
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Testbench for sobel_stream_ctrl.
// Uses three instances: 5x4 with latency 1, 5x4 with latency 3, and the default
// 297x240 frame. Every output is compared each cycle against a behavioural
// frame model.
module tb_sobel_stream_ctrl;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sobel_stream_ctrl_if #(.COORD_W(CW)) if_a ();
    sobel_stream_ctrl_if #(.COORD_W(CW)) if_b ();
    sobel_stream_ctrl_if #(.COORD_W(CW)) if_c ();

    sobel_stream_ctrl #(.FRAME_WIDTH(5), .FRAME_HEIGHT(4), .COORD_W(CW), .LATENCY(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    sobel_stream_ctrl #(.FRAME_WIDTH(5), .FRAME_HEIGHT(4), .COORD_W(CW), .LATENCY(3))
        dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    sobel_stream_ctrl #(.COORD_W(CW))
        dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    typedef struct {
        int due;
        int x;
        int y;
        bit last;
    } token_t;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     m_sel, m_w, m_h, m_lat;
    bit     m_act, m_err;
    int     m_r, m_c;
    int     held_x, held_y;
    int     win_seen, done_seen;
    token_t m_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic driveInputs(input logic en, input logic hs, input logic vs);
        if_a.en = 1'b0; if_a.hsync = 1'b0; if_a.vsync = 1'b0;
        if_b.en = 1'b0; if_b.hsync = 1'b0; if_b.vsync = 1'b0;
        if_c.en = 1'b0; if_c.hsync = 1'b0; if_c.vsync = 1'b0;
        case (m_sel)
            0:       begin if_a.en = en; if_a.hsync = hs; if_a.vsync = vs; end
            1:       begin if_b.en = en; if_b.hsync = hs; if_b.vsync = vs; end
            default: begin if_c.en = en; if_c.hsync = hs; if_c.vsync = vs; end
        endcase
    endtask

    task automatic readOutputs(output logic se, output logic wv, output logic fd, output logic le,
                               output logic [CW-1:0] wx, output logic [CW-1:0] wy);
        case (m_sel)
            0: begin
                se = if_a.shift_en; wv = if_a.win_valid; fd = if_a.frame_done;
                le = if_a.line_err; wx = if_a.win_x; wy = if_a.win_y;
            end
            1: begin
                se = if_b.shift_en; wv = if_b.win_valid; fd = if_b.frame_done;
                le = if_b.line_err; wx = if_b.win_x; wy = if_b.win_y;
            end
            default: begin
                se = if_c.shift_en; wv = if_c.win_valid; fd = if_c.frame_done;
                le = if_c.line_err; wx = if_c.win_x; wy = if_c.win_y;
            end
        endcase
    endtask

    task automatic selectDut(input int sel);
        m_sel = sel;
        case (sel)
            0:       begin m_w = 5;   m_h = 4;   m_lat = 1; end
            1:       begin m_w = 5;   m_h = 4;   m_lat = 3; end
            default: begin m_w = 297; m_h = 240; m_lat = 1; end
        endcase
    endtask

    task automatic modelReset();
        m_act = 1'b0; m_err = 1'b0; m_r = 0; m_c = 0;
        held_x = 0; held_y = 0;
        m_q.delete();
    endtask

    // Assert reset across a clock edge and confirm every output is cleared
    task automatic resetAll();
        logic se, wv, fd, le;
        logic [CW-1:0] wx, wy;
        @(negedge clk);
        reset = 1'b1;
        driveInputs(1'b0, 1'b0, 1'b0);
        #1;
        readOutputs(se, wv, fd, le, wx, wy);
        checkOutput("rst_shift_en", se, 0);
        checkOutput("rst_win_valid", wv, 0);
        checkOutput("rst_frame_done", fd, 0);
        checkOutput("rst_line_err", le, 0);
        checkOutput("rst_win_x", wx, 0);
        checkOutput("rst_win_y", wy, 0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus: model predicts acceptance and window tokens, then outputs are compared
    task automatic applyStimulus(input logic en, input logic hs, input logic vs);
        logic se, wv, fd, le;
        logic [CW-1:0] wx, wy;
        bit acc;
        int pr, pc;
        token_t t;
        @(negedge clk);
        driveInputs(en, hs, vs);
        #1;
        acc = vs ? en : (en && m_act);
        readOutputs(se, wv, fd, le, wx, wy);
        checkOutput("shift_en", se, acc);
        if (vs) begin
            m_r = 0; m_c = 0; m_err = 1'b0; m_act = 1'b1;
            m_q.delete();
        end
        if (acc) begin
            pr = m_r;
            pc = m_c;
            if (!vs && hs && m_c != 0) begin
                m_err = 1'b1;
                pr = m_r + 1;
                pc = 0;
            end
            if (pr >= 2 && pc >= 2) begin
                t.due  = cyc + m_lat;
                t.x    = pc - 1;
                t.y    = pr - 1;
                t.last = (pr == m_h - 1) && (pc == m_w - 1);
                m_q.push_back(t);
            end
            if (pc == m_w - 1) begin m_c = 0; m_r = pr + 1; end
            else begin m_c = pc + 1; m_r = pr; end
            if (pr == m_h - 1 && pc == m_w - 1) m_act = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        readOutputs(se, wv, fd, le, wx, wy);
        if (wv === 1'b1) win_seen++;
        if (fd === 1'b1) done_seen++;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            t = m_q.pop_front();
            checkOutput("win_valid", wv, 1);
            checkOutput("win_x", wx, t.x);
            checkOutput("win_y", wy, t.y);
            checkOutput("frame_done", fd, t.last);
            held_x = t.x;
            held_y = t.y;
        end else begin
            checkOutput("win_valid_idle", wv, 0);
            checkOutput("frame_done_idle", fd, 0);
            checkOutput("win_x_hold", wx, held_x);
            checkOutput("win_y_hold", wy, held_y);
        end
        checkOutput("line_err", le, m_err);
    endtask

    task automatic clearCounts();
        win_seen = 0;
        done_seen = 0;
    endtask

    initial begin
        int budget;
        reset = 1'b1;
        selectDut(0);
        driveInputs(1'b0, 1'b0, 1'b0);
        modelReset();
        clearCounts();
        resetAll();

        // Continuous frame: six windows, first at (1,1), last at (3,2) with frame_done
        $display("[TB] continuous 5x4 frame");
        applyStimulus(1'b1, 1'b0, 1'b0);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_win_count", win_seen, 6);
        checkOutput("t1_done_count", done_seen, 1);

        // Alternating en over the frame, with en also toggling after the frame ends
        $display("[TB] alternating en");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 44; i++) applyStimulus(i[0], 1'b0, 1'b0);
        checkOutput("t2_win_count", win_seen, 6);
        checkOutput("t2_done_count", done_seen, 1);

        // Early hsync in row 1 col 3 moves that pixel to (2,0) and raises line_err
        $display("[TB] early hsync");
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t3_err_model", m_err, 1);
        checkOutput("t3_row_model", m_r, 2);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_win_count", win_seen, 6);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3_err_cleared", if_a.line_err, 0);
        for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b0, 1'b0);

        // Randomized frames: random en, occasional hsync and mid-frame vsync
        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            applyStimulus($urandom_range(0, 1) == 1, 1'b0, 1'b1);
            budget = 0;
            while (m_act && budget < 400) begin
                applyStimulus($urandom_range(0, 9) < 7,
                              ($urandom_range(0, 7) == 0) && (m_r < m_h - 1),
                              $urandom_range(0, 59) == 0);
                budget++;
            end
            checkOutput("rand_frame_budget", budget < 400, 1);
            for (int i = 0; i < 4; i++) applyStimulus($urandom_range(0, 1) == 1, 1'b0, 1'b0);
        end

        // Reset pulsed mid-row 2; afterwards en without vsync is ignored
        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        driveInputs(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("t5_shift_en", if_a.shift_en, 0);
        checkOutput("t5_win_valid", if_a.win_valid, 0);
        checkOutput("t5_line_err", if_a.line_err, 0);
        checkOutput("t5_frame_done", if_a.frame_done, 0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0);

        // Latency 3: vsync while a window is in flight drops it and restarts at (0,0)
        $display("[TB] vsync with window in flight");
        selectDut(1);
        resetAll();
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_dropped", win_seen, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_win_count", win_seen, 6);
        checkOutput("t4_done_count", done_seen, 1);

        // Full default frame
        $display("[TB] full 297x240 frame");
        selectDut(2);
        resetAll();
        clearCounts();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 297 * 240; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6_win_count", win_seen, 70210);
        checkOutput("t6_done_count", done_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
